// File: rtl/lc4_regfile_2w4r.sv
// Dual-issue LC4 register file: four bypassed read ports, two write ports
// (port B is the younger instruction) and a per-register busy scoreboard.
module lc4_regfile_2w4r #(
  parameter  int unsigned n     = 16,
  parameter  int unsigned NREGS = 8,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gwe,
  input  logic [AW-1:0]    i_a_rs,
  output logic [n-1:0]     o_a_rs_data,
  input  logic [AW-1:0]    i_a_rt,
  output logic [n-1:0]     o_a_rt_data,
  input  logic [AW-1:0]    i_b_rs,
  output logic [n-1:0]     o_b_rs_data,
  input  logic [AW-1:0]    i_b_rt,
  output logic [n-1:0]     o_b_rt_data,
  input  logic [AW-1:0]    i_a_rd,
  input  logic [n-1:0]     i_a_wdata,
  input  logic             i_a_we,
  input  logic [AW-1:0]    i_b_rd,
  input  logic [n-1:0]     i_b_wdata,
  input  logic             i_b_we,
  input  logic             i_alloc_we,
  input  logic [AW-1:0]    i_alloc_rd,
  output logic [NREGS-1:0] o_busy
);

  logic [n-1:0]     regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic             wa;
  logic             wb;
  logic             wal;
  logic             a_byp;
  logic             b_byp;

  assign wa    = gwe & i_a_we;
  assign wb    = gwe & i_b_we;
  assign wal   = gwe & i_alloc_we;
  // Bypass is suppressed during reset so reads reflect the stored state.
  assign a_byp = wa & ~rst;
  assign b_byp = wb & ~rst;

  function automatic logic [n-1:0] read_port(
    input logic [AW-1:0] s,
    input logic          bb,
    input logic [AW-1:0] brd,
    input logic [n-1:0]  bdat,
    input logic          ab,
    input logic [AW-1:0] ard,
    input logic [n-1:0]  adat,
    input logic [n-1:0]  stored
  );
    if (bb && s == brd) begin
      return bdat;
    end else if (ab && s == ard) begin
      return adat;
    end
    return stored;
  endfunction

  always_comb begin
    o_a_rs_data = read_port(i_a_rs, b_byp, i_b_rd, i_b_wdata, a_byp, i_a_rd, i_a_wdata, regs[i_a_rs]);
    o_a_rt_data = read_port(i_a_rt, b_byp, i_b_rd, i_b_wdata, a_byp, i_a_rd, i_a_wdata, regs[i_a_rt]);
    o_b_rs_data = read_port(i_b_rs, b_byp, i_b_rd, i_b_wdata, a_byp, i_a_rd, i_a_wdata, regs[i_b_rs]);
    o_b_rt_data = read_port(i_b_rt, b_byp, i_b_rd, i_b_wdata, a_byp, i_a_rd, i_a_wdata, regs[i_b_rt]);
  end

  // Retiring writes clear first; a same-cycle dispatch then re-sets the bit.
  always_comb begin
    busy_nxt = busy_q;
    for (int unsigned k = 0; k < NREGS; k++) begin
      if ((wa && i_a_rd == AW'(k)) || (wb && i_b_rd == AW'(k))) begin
        busy_nxt[k] = 1'b0;
      end
      if (wal && i_alloc_rd == AW'(k)) begin
        busy_nxt[k] = 1'b1;
      end
    end
  end

  // Port B is written last so it wins a same-destination conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NREGS; k++) begin
        regs[k] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wa) begin
        regs[i_a_rd] <= i_a_wdata;
      end
      if (wb) begin
        regs[i_b_rd] <= i_b_wdata;
      end
      busy_q <= busy_nxt;
    end
  end

  assign o_busy = busy_q;

endmodule

// File: tb/tb_lc4_regfile_2w4r.sv
// Self-checking bench for lc4_regfile_2w4r: directed scenarios plus random
// traffic against an array/bit-vector model, and a 32-bit/16-register instance.
module tb_lc4_regfile_2w4r;

  logic        clk = 1'b0;
  logic        rst, gwe;
  logic [2:0]  a_rs, a_rt, b_rs, b_rt, a_rd, b_rd, alloc_rd;
  logic [15:0] a_rs_data, a_rt_data, b_rs_data, b_rt_data, a_wdata, b_wdata;
  logic        a_we, b_we, alloc_we;
  logic [7:0]  busy;

  logic [3:0]  p_a_rs, p_a_rt, p_b_rs, p_b_rt, p_a_rd, p_b_rd, p_alloc_rd;
  logic [31:0] p_a_rs_data, p_a_rt_data, p_b_rs_data, p_b_rt_data, p_a_wdata, p_b_wdata;
  logic        p_a_we, p_b_we, p_alloc_we;
  logic [15:0] p_busy;

  logic [15:0] mdl [8];
  logic [7:0]  mbusy;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  lc4_regfile_2w4r dut (
    .clk(clk), .rst(rst), .gwe(gwe),
    .i_a_rs(a_rs), .o_a_rs_data(a_rs_data), .i_a_rt(a_rt), .o_a_rt_data(a_rt_data),
    .i_b_rs(b_rs), .o_b_rs_data(b_rs_data), .i_b_rt(b_rt), .o_b_rt_data(b_rt_data),
    .i_a_rd(a_rd), .i_a_wdata(a_wdata), .i_a_we(a_we),
    .i_b_rd(b_rd), .i_b_wdata(b_wdata), .i_b_we(b_we),
    .i_alloc_we(alloc_we), .i_alloc_rd(alloc_rd), .o_busy(busy)
  );

  lc4_regfile_2w4r #(.n(32), .NREGS(16)) dut_p (
    .clk(clk), .rst(rst), .gwe(gwe),
    .i_a_rs(p_a_rs), .o_a_rs_data(p_a_rs_data), .i_a_rt(p_a_rt), .o_a_rt_data(p_a_rt_data),
    .i_b_rs(p_b_rs), .o_b_rs_data(p_b_rs_data), .i_b_rt(p_b_rt), .o_b_rt_data(p_b_rt_data),
    .i_a_rd(p_a_rd), .i_a_wdata(p_a_wdata), .i_a_we(p_a_we),
    .i_b_rd(p_b_rd), .i_b_wdata(p_b_wdata), .i_b_we(p_b_we),
    .i_alloc_we(p_alloc_we), .i_alloc_rd(p_alloc_rd), .o_busy(p_busy)
  );

  // Expected value at a read address: the youngest same-cycle write wins,
  // otherwise the architectural contents.
  function automatic logic [15:0] exp_read(input logic [2:0] s);
    logic [15:0] v;
    v = mdl[s];
    if (!rst && gwe) begin
      if (a_we && a_rd == s) v = a_wdata;
      if (b_we && b_rd == s) v = b_wdata;
    end
    return v;
  endfunction

  task automatic idle();
    rst = 1'b0; gwe = 1'b1;
    a_we = 1'b0; b_we = 1'b0; alloc_we = 1'b0;
    a_rd = '0; b_rd = '0; alloc_rd = '0; a_wdata = '0; b_wdata = '0;
    p_a_we = 1'b0; p_b_we = 1'b0; p_alloc_we = 1'b0;
    p_a_rd = '0; p_b_rd = '0; p_alloc_rd = '0; p_a_wdata = '0; p_b_wdata = '0;
    p_a_rs = '0; p_a_rt = '0; p_b_rs = '0; p_b_rt = '0;
  endtask

  // Advance the model by the current inputs, then clock the DUT.
  task automatic tick();
    logic [7:0] nb;
    if (rst) begin
      for (int i = 0; i < 8; i++) mdl[i] = '0;
      mbusy = '0;
    end else if (gwe) begin
      nb = mbusy;
      if (a_we) begin mdl[a_rd] = a_wdata; nb[a_rd] = 1'b0; end
      if (b_we) begin mdl[b_rd] = b_wdata; nb[b_rd] = 1'b0; end
      if (alloc_we) nb[alloc_rd] = 1'b1;
      mbusy = nb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    for (int i = 0; i < 8; i += 2) begin
      a_we = 1'b1; a_rd = 3'(i);     a_wdata = 16'hFFFF;
      b_we = 1'b1; b_rd = 3'(i + 1); b_wdata = 16'hFFFF;
      alloc_we = 1'b1; alloc_rd = 3'(i);
      tick();
    end
    rst = 1'b1; a_we = 1'b1; a_rd = 3'd1; a_wdata = 16'h1234;
    a_rs = 3'd1; a_rt = 3'd2; b_rs = 3'd3; b_rt = 3'd4;
    #2;
    n_checks++;
    if (a_rs_data !== 16'hFFFF) begin
      n_fail++; $display("FAIL reset_no_bypass: got %h want FFFF", a_rs_data);
    end
    tick();
    idle();
    for (int i = 0; i < 8; i += 4) begin
      a_rs = 3'(i); a_rt = 3'(i + 1); b_rs = 3'(i + 2); b_rt = 3'(i + 3);
      #1;
      n_checks++;
      if ({a_rs_data, a_rt_data, b_rs_data, b_rt_data} !== 64'h0) begin
        n_fail++;
        $display("FAIL reset_regs[%0d]: got %h %h %h %h want 0", i, a_rs_data, a_rt_data, b_rs_data, b_rt_data);
      end
    end
    n_checks++;
    if (busy !== 8'h00) begin
      n_fail++; $display("FAIL reset_busy: got %h want 00", busy);
    end
  endtask

  task automatic test_bypass();
    idle();
    a_we = 1'b1; a_rd = 3'd3; a_wdata = 16'h1111;
    tick();
    a_wdata = 16'h2222; a_rs = 3'd3;
    #2;
    n_checks++;
    if (a_rs_data !== 16'h2222) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h want 2222", a_rs_data);
    end
    tick();
    idle();
    #2;
    n_checks++;
    if (a_rs_data !== 16'h2222) begin
      n_fail++; $display("FAIL bypass_stored: got %h want 2222", a_rs_data);
    end
  endtask

  task automatic test_dual_write();
    idle();
    a_we = 1'b1; a_rd = 3'd5; a_wdata = 16'hAAAA;
    b_we = 1'b1; b_rd = 3'd5; b_wdata = 16'hBBBB;
    b_rt = 3'd5; a_rt = 3'd5;
    #2;
    n_checks++;
    if (b_rt_data !== 16'hBBBB || a_rt_data !== 16'hBBBB) begin
      n_fail++; $display("FAIL dual_same_cycle: got %h/%h want BBBB", b_rt_data, a_rt_data);
    end
    tick();
    idle();
    #2;
    n_checks++;
    if (b_rt_data !== 16'hBBBB) begin
      n_fail++; $display("FAIL dual_stored: got %h want BBBB", b_rt_data);
    end
  endtask

  task automatic test_gwe_low();
    idle();
    a_we = 1'b1; a_rd = 3'd2; a_wdata = 16'h0042;
    alloc_we = 1'b1; alloc_rd = 3'd6;
    tick();
    idle();
    gwe = 1'b0;
    a_we = 1'b1; a_rd = 3'd2; a_wdata = 16'h1234;
    b_we = 1'b1; b_rd = 3'd6; b_wdata = 16'h5555;
    alloc_we = 1'b1; alloc_rd = 3'd1;
    a_rs = 3'd2; b_rs = 3'd6;
    #2;
    n_checks++;
    if (a_rs_data !== 16'h0042 || b_rs_data !== 16'h0000) begin
      n_fail++; $display("FAIL gwe_low_read: got %h/%h want 0042/0000", a_rs_data, b_rs_data);
    end
    tick();
    gwe = 1'b1; a_we = 1'b0; b_we = 1'b0; alloc_we = 1'b0;
    #2;
    n_checks++;
    if (a_rs_data !== 16'h0042) begin
      n_fail++; $display("FAIL gwe_low_next: got %h want 0042", a_rs_data);
    end
    n_checks++;
    if (busy !== 8'h40) begin
      n_fail++; $display("FAIL gwe_low_busy: got %h want 40", busy);
    end
    a_we = 1'b1; a_rd = 3'd6; a_wdata = 16'h0006;
    tick();
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    alloc_we = 1'b1; alloc_rd = 3'd4;
    #2;
    n_checks++;
    if (busy !== 8'h00) begin
      n_fail++; $display("FAIL busy_registered: got %h want 00", busy);
    end
    tick();
    n_checks++;
    if (busy !== 8'h10) begin
      n_fail++; $display("FAIL busy_alloc: got %h want 10", busy);
    end
    b_we = 1'b1; b_rd = 3'd4; b_wdata = 16'h0404;
    tick();
    n_checks++;
    if (busy !== 8'h10) begin
      n_fail++; $display("FAIL busy_set_wins: got %h want 10", busy);
    end
    idle();
    a_we = 1'b1; a_rd = 3'd4; a_wdata = 16'h4444;
    tick();
    n_checks++;
    if (busy !== 8'h00) begin
      n_fail++; $display("FAIL busy_clear: got %h want 00", busy);
    end
    b_we = 1'b1; b_rd = 3'd7; b_wdata = 16'h7777;
    tick();
    idle();
    n_checks++;
    if (busy !== 8'h00) begin
      n_fail++; $display("FAIL busy_nonbusy_write: got %h want 00", busy);
    end
  endtask

  task automatic test_random();
    logic [15:0] e0, e1, e2, e3;
    for (int c = 0; c < 300; c++) begin
      rst      = ($urandom_range(0, 49) == 0);
      gwe      = ($urandom_range(0, 7) != 0);
      a_we     = 1'($urandom);
      b_we     = 1'($urandom);
      alloc_we = 1'($urandom);
      a_rd = 3'($urandom); b_rd = 3'($urandom); alloc_rd = 3'($urandom);
      a_wdata = 16'($urandom); b_wdata = 16'($urandom);
      a_rs = 3'($urandom); a_rt = 3'($urandom); b_rs = 3'($urandom); b_rt = 3'($urandom);
      if (c % 5 == 0) begin a_rs = a_rd; b_rt = b_rd; end
      #2;
      e0 = exp_read(a_rs); e1 = exp_read(a_rt); e2 = exp_read(b_rs); e3 = exp_read(b_rt);
      n_checks++;
      if (a_rs_data !== e0 || a_rt_data !== e1 || b_rs_data !== e2 || b_rt_data !== e3) begin
        n_fail++;
        $display("FAIL rand_read c=%0d: got %h %h %h %h want %h %h %h %h",
                 c, a_rs_data, a_rt_data, b_rs_data, b_rt_data, e0, e1, e2, e3);
      end
      n_checks++;
      if (busy !== mbusy) begin
        n_fail++; $display("FAIL rand_busy c=%0d: got %h want %h", c, busy, mbusy);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_param();
    idle();
    p_a_we = 1'b1; p_a_rd = 4'd15; p_a_wdata = 32'hDEADBEEF;
    p_alloc_we = 1'b1; p_alloc_rd = 4'd15;
    p_b_rs = 4'd15;
    #2;
    n_checks++;
    if (p_b_rs_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL param_bypass: got %h want DEADBEEF", p_b_rs_data);
    end
    tick();
    idle();
    p_a_rs = 4'd15; p_a_rt = 4'd15; p_b_rs = 4'd15; p_b_rt = 4'd15;
    #2;
    n_checks++;
    if (p_a_rs_data !== 32'hDEADBEEF || p_a_rt_data !== 32'hDEADBEEF ||
        p_b_rs_data !== 32'hDEADBEEF || p_b_rt_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL param_read: got %h %h %h %h want DEADBEEF",
               p_a_rs_data, p_a_rt_data, p_b_rs_data, p_b_rt_data);
    end
    n_checks++;
    if (p_busy !== 16'h8000) begin
      n_fail++; $display("FAIL param_busy: got %h want 8000", p_busy);
    end
    p_a_rs = 4'd7;
    #1;
    n_checks++;
    if (p_a_rs_data !== 32'h0) begin
      n_fail++; $display("FAIL param_other_reg: got %h want 0", p_a_rs_data);
    end
  endtask

  initial begin
    idle();
    a_rs = '0; a_rt = '0; b_rs = '0; b_rt = '0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    mbusy = '0;
    rst = 1'b1;
    tick();
    tick();
    test_reset();
    test_bypass();
    test_dual_write();
    test_gwe_low();
    test_scoreboard();
    test_random();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
